// File: rtl/dbus_wb_if_if.sv
// Wishbone B4 classic data-bus signal bundle between the CPU data-bus
// interface (master) and the external data bus (slave).
//   wb_adr_o  32  address               master -> slave
//   wb_dat_o  32  write data            master -> slave
//   wb_we_o    1  write enable          master -> slave
//   wb_sel_o   4  byte select           master -> slave
//   wb_stb_o   1  strobe                master -> slave
//   wb_cyc_o   1  cycle                 master -> slave
//   wb_dat_i  32  read data             slave  -> master
//   wb_ack_i   1  acknowledge           slave  -> master
interface dbus_wb_if_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/dbus_wb_if.sv
// MEM-stage to Wishbone B4 classic data-bus interface.
// Turns a single-cycle MEM request into a registered Wishbone cycle, stalls
// the pipeline until ack, and buffers the read word while MEM is frozen.
// Optional feature macro: DBUS_TIMEOUT_EN (BUSY watchdog, TIMEOUT_CYCLES).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall_i[5:0]    pipeline stall vector (bit 4 = MEM held)
//   flush_i         abandon any request in flight
//   cpu_ce_i/we_i   request valid / write
//   cpu_addr_i      byte address (passed through unmodified)
//   cpu_sel_i       byte lanes (bit3 = data[31:24])
//   cpu_data_i      store data
//   cpu_data_o      read word to MEM (combinational)
//   stallreq_o      hold request to the pipeline controller (combinational)
//   bus_err_o       one-cycle timeout pulse (0 without DBUS_TIMEOUT_EN)
//   wb              Wishbone master port (registered outputs)
module dbus_wb_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [31:0]         cpu_addr_i,
  input  logic [3:0]          cpu_sel_i,
  input  logic [31:0]         cpu_data_i,
  output logic [31:0]         cpu_data_o,
  output logic                stallreq_o,
  output logic                bus_err_o,
  dbus_wb_if_if.master        wb
);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

  state_t      state, state_n;
  logic [31:0] rd_buf;
  logic        issue;      // accept a new request this cycle
  logic        done;       // access completes this cycle (ack or timeout)
  logic        abort;      // flush while the bus cycle is open
  logic [31:0] done_data;
  logic        tmo;
  logic        err;

  logic unused_stall;
  assign unused_stall = ^{stall_i[5], stall_i[3:0]};

`ifdef DBUS_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Counts only cycles that remain in BUSY; any exit clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == BUSY && state_n == BUSY) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo       = (tmo_cnt == 8'(TIMEOUT_CYCLES));
  assign bus_err_o = err;
`else
  // Limit range is 1..255, so this never fires: BUSY waits for ack.
  assign tmo       = (TIMEOUT_CYCLES == 0);
  assign bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    issue      = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    done_data  = '0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          issue      = 1'b1;
          stallreq_o = 1'b1;
          state_n    = BUSY;
        end
      end
      BUSY: begin
        if (flush_i) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (wb.wb_ack_i) begin
          done      = 1'b1;
          done_data = wb.wb_dat_i;
        end else if (tmo) begin
          done = 1'b1;
          err  = 1'b1;
        end else begin
          stallreq_o = 1'b1;
        end
        if (done) begin
          cpu_data_o = done_data;
          state_n    = stall_i[4] ? WAIT_STALL : IDLE;
        end
      end
      WAIT_STALL: begin
        cpu_data_o = rd_buf;
        if (flush_i || !stall_i[4]) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= '0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_sel_o <= '0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_cyc_o <= 1'b0;
      rd_buf      <= '0;
    end else begin
      if (issue) begin
        wb.wb_adr_o <= cpu_addr_i;
        wb.wb_dat_o <= cpu_data_i;
        wb.wb_we_o  <= cpu_we_i;
        wb.wb_sel_o <= cpu_sel_i;
        wb.wb_stb_o <= 1'b1;
        wb.wb_cyc_o <= 1'b1;
      end else if (done || abort) begin
        wb.wb_we_o  <= 1'b0;
        wb.wb_sel_o <= '0;
        wb.wb_stb_o <= 1'b0;
        wb.wb_cyc_o <= 1'b0;
      end
      if (done) begin
        rd_buf <= done_data;
      end
    end
  end

endmodule

// File: tb/tb_dbus_wb_if.sv
module tb_dbus_wb_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] cpu_data;
  logic        stallreq;
  logic        bus_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] exp_q[$];

  dbus_wb_if_if bus();

  dbus_wb_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall),
    .flush_i    (flush),
    .cpu_ce_i   (ce),
    .cpu_we_i   (we),
    .cpu_addr_i (addr),
    .cpu_sel_i  (sel),
    .cpu_data_i (wdata),
    .cpu_data_o (cpu_data),
    .stallreq_o (stallreq),
    .bus_err_o  (bus_err),
    .wb         (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      chk(tag, cpu_data, exp_q.pop_front());
    end
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d);
    ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; ce = 1'b0; we = 1'b0;
    addr = '0; sel = '0; wdata = '0;
    bus.wb_ack_i = 1'b0; bus.wb_dat_i = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_cyc", 32'(bus.wb_cyc_o), 0);
    chk("rst_stb", 32'(bus.wb_stb_o), 0);
    chk("rst_adr", bus.wb_adr_o, 0);
    chk("rst_stallreq", 32'(stallreq), 0);
    chk("rst_cpu_data", cpu_data, 0);
    chk("rst_bus_err", 32'(bus_err), 0);

    // Zero-wait read
    tick();
    req(1'b0, 32'h100, 4'b1111, 32'h0);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    chk("zw_req_stallreq", 32'(stallreq), 1);
    chk("zw_req_cpu_data", cpu_data, 0);
    tick();
    ce = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hDEADBEEF;
    #1;
    chk("zw_cyc", 32'(bus.wb_cyc_o), 1);
    chk("zw_stb", 32'(bus.wb_stb_o), 1);
    chk("zw_adr", bus.wb_adr_o, 32'h100);
    chk("zw_sel", 32'(bus.wb_sel_o), 32'hF);
    chk("zw_we", 32'(bus.wb_we_o), 0);
    chk("zw_stallreq", 32'(stallreq), 0);
    chk_pop("zw_data");
    tick();
    bus.wb_ack_i = 1'b0; bus.wb_dat_i = '0;
    #1;
    chk("zw_after_cyc", 32'(bus.wb_cyc_o), 0);
    chk("zw_after_stb", 32'(bus.wb_stb_o), 0);

    // Byte write, 3 wait states
    tick();
    req(1'b1, 32'h203, 4'b0001, 32'h5A5A5A5A);
    exp_q.push_back(32'hCAFEF00D);
    #1;
    chk("wr_req_stallreq", 32'(stallreq), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      ce = 1'b0;
      #1;
      chk("wr_wait_sel", 32'(bus.wb_sel_o), 32'h1);
      chk("wr_wait_dat", bus.wb_dat_o, 32'h5A5A5A5A);
      chk("wr_wait_we", 32'(bus.wb_we_o), 1);
      chk("wr_wait_adr", bus.wb_adr_o, 32'h203);
      chk("wr_wait_stallreq", 32'(stallreq), 1);
    end
    tick();
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hCAFEF00D;
    #1;
    chk("wr_ack_sel", 32'(bus.wb_sel_o), 32'h1);
    chk("wr_ack_dat", bus.wb_dat_o, 32'h5A5A5A5A);
    chk("wr_ack_stallreq", 32'(stallreq), 0);
    chk_pop("wr_ack_data");
    tick();
    bus.wb_ack_i = 1'b0;
    #1;
    chk("wr_after_cyc", 32'(bus.wb_cyc_o), 0);
    chk("wr_after_we", 32'(bus.wb_we_o), 0);
    chk("wr_after_sel", 32'(bus.wb_sel_o), 0);

    // Ack while MEM is held: data buffered, no re-issue
    tick();
    req(1'b0, 32'h180, 4'b1111, 32'h0);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h12345678);
    tick();
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h12345678; stall = 6'b010000;
    #1;
    chk("ws_ack_stallreq", 32'(stallreq), 0);
    chk_pop("ws_ack_data");
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'hFFFFFFFF;
      #1;
      chk("ws_hold_stb", 32'(bus.wb_stb_o), 0);
      chk("ws_hold_cyc", 32'(bus.wb_cyc_o), 0);
      chk("ws_hold_stallreq", 32'(stallreq), 0);
      chk_pop("ws_hold_data");
    end
    tick();
    stall = '0; ce = 1'b0;
    #1;
    chk_pop("ws_release_data");
    tick();
    #1;
    chk("ws_idle_cyc", 32'(bus.wb_cyc_o), 0);
    chk("ws_idle_stallreq", 32'(stallreq), 0);
    chk("ws_idle_data", cpu_data, 0);

    // Flush during BUSY with simultaneous ack
    req(1'b0, 32'h300, 4'b1111, 32'h0);
    tick();
    ce = 1'b0; flush = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hBAD0BAD0;
    #1;
    chk("fl_stallreq", 32'(stallreq), 0);
    chk("fl_cpu_data", cpu_data, 0);
    tick();
    flush = 1'b0; bus.wb_ack_i = 1'b0;
    #1;
    chk("fl_after_cyc", 32'(bus.wb_cyc_o), 0);
    chk("fl_after_stb", 32'(bus.wb_stb_o), 0);
    req(1'b0, 32'h400, 4'b1100, 32'h0);
    exp_q.push_back(32'h0BADF00D);
    #1;
    chk("fl_next_stallreq", 32'(stallreq), 1);
    tick();
    ce = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h0BADF00D;
    #1;
    chk("fl_next_adr", bus.wb_adr_o, 32'h400);
    chk("fl_next_sel", 32'(bus.wb_sel_o), 32'hC);
    chk_pop("fl_next_data");
    tick();
    bus.wb_ack_i = 1'b0;

    // Reset mid-BUSY
    req(1'b1, 32'h500, 4'b1111, 32'h77777777);
    tick();
    ce = 1'b0;
    #1;
    chk("rb_cyc", 32'(bus.wb_cyc_o), 1);
    rst = 1'b1;
    tick();
    #1;
    chk("rb_cyc0", 32'(bus.wb_cyc_o), 0);
    chk("rb_stb0", 32'(bus.wb_stb_o), 0);
    chk("rb_adr0", bus.wb_adr_o, 0);
    chk("rb_dat0", bus.wb_dat_o, 0);
    chk("rb_we0", 32'(bus.wb_we_o), 0);
    chk("rb_sel0", 32'(bus.wb_sel_o), 0);
    chk("rb_stallreq0", 32'(stallreq), 0);
    chk("rb_data0", cpu_data, 0);
    tick();
    rst = 1'b0;
    req(1'b0, 32'h600, 4'b1111, 32'h0);
    exp_q.push_back(32'h600D600D);
    #1;
    chk("rb_idle_stallreq", 32'(stallreq), 1);
    tick();
    ce = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h600D600D;
    #1;
    chk_pop("rb_idle_data");
    tick();
    bus.wb_ack_i = 1'b0;

    // Slave never acks
    req(1'b0, 32'h700, 4'b1111, 32'h0);
`ifdef DBUS_TIMEOUT_EN
    exp_q.push_back(32'h0);
    tick();
    ce = 1'b0; bus.wb_dat_i = 32'hEEEEEEEE;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_busy_stallreq", 32'(stallreq), 1);
      chk("to_busy_err", 32'(bus_err), 0);
      tick();
    end
    #1;
    chk("to_fire_stallreq", 32'(stallreq), 0);
    chk("to_fire_err", 32'(bus_err), 1);
    chk_pop("to_fire_data");
    tick();
    #1;
    chk("to_after_cyc", 32'(bus.wb_cyc_o), 0);
    chk("to_after_err", 32'(bus_err), 0);
`else
    exp_q.push_back(32'h0A0B0C0D);
    tick();
    ce = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("nt_busy_stallreq", 32'(stallreq), 1);
      chk("nt_busy_err", 32'(bus_err), 0);
      tick();
    end
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h0A0B0C0D;
    #1;
    chk("nt_ack_stallreq", 32'(stallreq), 0);
    chk_pop("nt_ack_data");
    tick();
    bus.wb_ack_i = 1'b0;
    #1;
    chk("nt_after_cyc", 32'(bus.wb_cyc_o), 0);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_wb_if.md
# dbus_wb_if

Data-bus interface between the MEM stage and the external Wishbone data bus. It turns the MEM stage's single-cycle memory request into a registered Wishbone B4 classic cycle and returns the read word on the MEM stage's read-data input. It holds the pipeline with a stall request until the bus acknowledges, and buffers the returned word while the pipeline controller keeps MEM frozen.

## Interface
- TIMEOUT_CYCLES, 255, cycles in BUSY without ack before forced completion; used only with DBUS_TIMEOUT_EN; range 1..255.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- stall_i  in  6  pipeline-controller stall vector; bit 4 = MEM stage held this cycle
- flush_i  in  1  pipeline flush; abandons any request in flight
- cpu_ce_i  in  1  MEM request valid (MEM chip enable)
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_addr_i  in  32  byte address, already aligned by MEM for LWL/LWR/SWL/SWR
- cpu_sel_i  in  4  byte lanes, big-endian: bit3 = data[31:24]
- cpu_data_i  in  32  store data, already lane-replicated by MEM
- cpu_data_o  out  32  read word to MEM
- stallreq_o  out  1  request to the pipeline controller to hold the pipeline
- bus_err_o  out  1  one-cycle timeout pulse; constant 0 without DBUS_TIMEOUT_EN
- wb_adr_o  out  32  registered address
- wb_dat_o  out  32  registered write data
- wb_we_o  out  1  registered write enable
- wb_sel_o  out  4  registered byte select
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_dat_i  in  32  bus read data
- wb_ack_i  in  1  bus acknowledge

## Operation
- States: IDLE, BUSY, WAIT_STALL. Reset enters IDLE.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0, register adr/dat/we/sel from the cpu_* inputs, set cyc=stb=1, and go to BUSY.
  - stallreq_o=1 combinationally in this cycle.
  - cpu_data_o=0.
- BUSY, wb_ack_i=0: stallreq_o=1; wb_* outputs hold stable.
- BUSY, wb_ack_i=1:
  - cpu_data_o=wb_dat_i combinationally and stallreq_o=0.
  - Latch wb_dat_i into rd_buf and clear cyc/stb/we/sel.
  - Next state is WAIT_STALL if stall_i[4]=1, else IDLE.
- WAIT_STALL:
  - cpu_data_o=rd_buf and stallreq_o=0; no bus activity.
  - Go to IDLE when stall_i[4]=0.
  - Prevents re-issuing a completed access while MEM is frozen by another stage's stall.
- flush_i=1 takes priority in any state:
  - Next state is IDLE; cyc/stb clear on the next edge.
  - stallreq_o=0 in the flush cycle.
  - A simultaneous ack is discarded.
- Writes follow the same sequence. cpu_data_o carries bus data, which MEM ignores.
- Only one outstanding access. No burst, no pipelined Wishbone mode.
- Address and sel pass through unmodified; no lane rearrangement.

## Timing
- Reset values: all wb_* outputs 0, cpu_data_o 0, stallreq_o 0, bus_err_o 0, rd_buf 0, timeout counter 0.
- Request seen in IDLE at cycle N gives wb_cyc_o=1 at N+1.
- With a zero-wait slave (ack at N+1), data is returned at N+1, stallreq_o is high only in N, and the minimum access is 2 cycles.
- Each wait state adds one cycle of stallreq_o.
- Back-to-back MEM accesses: the next request is accepted in IDLE at N+2 at the earliest.
- wb_* outputs are registered; stallreq_o and cpu_data_o are combinational from state, wb_ack_i, wb_dat_i and flush_i.

## Configuration
- DBUS_TIMEOUT_EN defined:
  - An 8-bit counter increments every BUSY cycle with ack=0 and clears on leaving BUSY.
  - When the counter reaches TIMEOUT_CYCLES, the access completes as if acked with data 32'h0000_0000, and bus_err_o=1 for that cycle.
- DBUS_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely for ack; bus_err_o tied 0.

## Test plan
- Zero-wait read: cpu_ce=1, we=0, addr=0x100, sel=4'b1111, slave acks at the first stb with 0xDEADBEEF -> stallreq high 1 cycle; cpu_data_o=0xDEADBEEF in the ack cycle; wb_cyc low the next cycle.
- Byte write with 3 wait states: we=1, addr=0x203, sel=4'b0001, data=0x5A5A5A5A -> wb_sel_o=0001 and wb_dat_o=0x5A5A5A5A held for 4 cycles; stallreq high 4 cycles.
- Ack while stall_i[4]=1 for 3 cycles, read data 0x12345678 -> state WAIT_STALL; cpu_data_o=0x12345678 for all 3 cycles; no second stb; stallreq 0.
- flush_i=1 during BUSY with ack in the same cycle -> stallreq 0; cyc/stb 0 on the next edge; returns to IDLE; the next request starts cleanly.
- rst=1 mid-BUSY -> all outputs 0 on the next edge; state IDLE.
- DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks -> stallreq drops and bus_err_o pulses 1 cycle after 4 BUSY cycles; cpu_data_o=0; without the macro stallreq stays high.
